// File: rtl/pokey_div_chan.sv
// Programmable N-bit down-counter channel: divisor latch, forced load, tick-qualified
// decrement, reload on underflow and registered borrow. Optional square-wave output via POKEY_DIV_TOGGLE_EN.
module pokey_div_chan #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] LATCH_RST = '0
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             enn,
  input  logic             tick,
  input  logic             hold,
  input  logic             WR,
  input  logic [WIDTH-1:0] D,
  input  logic             Ld,
  output logic [WIDTH-1:0] cnt,
  output logic             BOR,
  output logic             nBOR,
  output logic             tgl
);

  logic [WIDTH-1:0] latch_reg;
  logic [WIDTH-1:0] cnt_reg;
  logic [WIDTH-1:0] reload;
  logic             bor_reg;
  logic             count_en;
  logic             underflow;

  // A write in the same cycle as a reload is forwarded so the fresh divisor is used at once.
  assign reload    = WR ? D : latch_reg;
  assign count_en  = tick & ~hold;
  assign underflow = ~Ld & count_en & (cnt_reg == '0);

  always_ff @(negedge clk or negedge nrst) begin
    if (!nrst) begin
      latch_reg <= LATCH_RST;
      cnt_reg   <= LATCH_RST;
      bor_reg   <= 1'b0;
    end else if (enn) begin
      if (WR) begin
        latch_reg <= D;
      end
      if (Ld) begin
        cnt_reg <= reload;
        bor_reg <= 1'b0;
      end else if (underflow) begin
        cnt_reg <= reload;
        bor_reg <= 1'b1;
      end else if (count_en) begin
        cnt_reg <= cnt_reg - 1'b1;
        bor_reg <= 1'b0;
      end else begin
        bor_reg <= 1'b0;
      end
    end
  end

`ifdef POKEY_DIV_TOGGLE_EN
  logic tgl_reg;

  // Flips exactly when a borrow is being registered; loads and writes leave it alone.
  always_ff @(negedge clk or negedge nrst) begin
    if (!nrst) begin
      tgl_reg <= 1'b0;
    end else if (enn && underflow) begin
      tgl_reg <= ~tgl_reg;
    end
  end

  assign tgl = tgl_reg;
`else
  assign tgl = 1'b0;
`endif

  assign cnt  = cnt_reg;
  assign BOR  = bor_reg;
  assign nBOR = ~bor_reg;

endmodule

// File: tb/tb_pokey_div_chan.sv
// Bench for pokey_div_chan: behavioural model checked every cycle plus directed
// literal sequences, a cascaded pair, and randomized traffic with async reset pulses.
module tb_pokey_div_chan;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             nrst;
  logic             enn, tick, hold, wr, ld;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] cnt;
  logic             bor, nbor, tgl;

  logic             c_ld, c_wr, lo_tick, lo_hold;
  logic [WIDTH-1:0] lo_d, hi_d, lo_cnt, hi_cnt;
  logic             lo_bor, lo_nbor, lo_tgl, hi_bor, hi_nbor, hi_tgl;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  int m_latch, m_cnt, m_bor, m_tgl;

  always #5 clk = ~clk;

  pokey_div_chan #(.WIDTH(WIDTH), .LATCH_RST('0)) dut (
    .clk(clk), .nrst(nrst), .enn(enn), .tick(tick), .hold(hold), .WR(wr), .D(d), .Ld(ld),
    .cnt(cnt), .BOR(bor), .nBOR(nbor), .tgl(tgl)
  );

  pokey_div_chan #(.WIDTH(WIDTH), .LATCH_RST('0)) lo (
    .clk(clk), .nrst(nrst), .enn(1'b1), .tick(lo_tick), .hold(lo_hold), .WR(c_wr), .D(lo_d),
    .Ld(c_ld), .cnt(lo_cnt), .BOR(lo_bor), .nBOR(lo_nbor), .tgl(lo_tgl)
  );

  pokey_div_chan #(.WIDTH(WIDTH), .LATCH_RST('0)) hi (
    .clk(clk), .nrst(nrst), .enn(1'b1), .tick(lo_bor), .hold(1'b0), .WR(c_wr), .D(hi_d),
    .Ld(c_ld), .cnt(hi_cnt), .BOR(hi_bor), .nBOR(hi_nbor), .tgl(hi_tgl)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference: what one enabled falling edge does, in plain integer terms.
  always @(negedge clk or negedge nrst) begin
    if (!nrst) begin
      m_latch = 0; m_cnt = 0; m_bor = 0; m_tgl = 0;
    end else if (enn) begin
      int nxt_div;
      nxt_div = wr ? int'(d) : m_latch;
      if (wr) m_latch = int'(d);
      if (ld) begin
        m_cnt = nxt_div; m_bor = 0;
      end else if (tick && !hold) begin
        if (m_cnt == 0) begin
          m_cnt = nxt_div; m_bor = 1;
`ifdef POKEY_DIV_TOGGLE_EN
          m_tgl = 1 - m_tgl;
`endif
        end else begin
          m_cnt = m_cnt - 1; m_bor = 0;
        end
      end else begin
        m_bor = 0;
      end
    end
  end

  always @(posedge clk) begin
    if (chk_en) begin
      chk("model_cnt", 32'(cnt), 32'(m_cnt));
      chk("model_bor", 32'(bor), 32'(m_bor));
      chk("model_nbor", 32'(nbor), 32'(1 - m_bor));
      chk("model_tgl", 32'(tgl), 32'(m_tgl));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enn = 1'b1; tick = 1'b0; hold = 1'b0; wr = 1'b0; ld = 1'b0; d = '0;
  endtask

  int exp_c[8] = '{2, 1, 0, 3, 2, 1, 0, 3};
  int exp_b[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
  int exp4_c[6] = '{2, 1, 0, 1, 0, 1};
  int exp4_b[6] = '{0, 0, 0, 1, 0, 1};

  initial begin
    int pulses[4];
    int np, cyc, flips, frozen_lo, frozen_hi;
    logic prev_tgl;

    nrst = 1'b1; idle();
    c_ld = 1'b0; c_wr = 1'b0; lo_tick = 1'b0; lo_hold = 1'b0; lo_d = '0; hi_d = '0;

    // Reset acts without any clock edge.
    #1 nrst = 1'b0;
    #1;
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_bor", 32'(bor), 32'd0);
    chk("rst_nbor", 32'(nbor), 32'd1);
    chk("rst_tgl", 32'(tgl), 32'd0);
    step();
    nrst = 1'b1;
    chk_en = 1'b1;

    // Divisor 3: four-tick period.
    wr = 1'b1; d = 8'd3; step();
    wr = 1'b0; ld = 1'b1; step();
    chk("ld_cnt", 32'(cnt), 32'd3);
    ld = 1'b0; tick = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("div3_cnt%0d", i), 32'(cnt), 32'(exp_c[i]));
      chk($sformatf("div3_bor%0d", i), 32'(bor), 32'(exp_b[i]));
    end
    enn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("freeze_cnt", 32'(cnt), 32'd3);
      chk("freeze_bor", 32'(bor), 32'd1);
    end
    enn = 1'b1; step();
    chk("resume_cnt", 32'(cnt), 32'd2);
    chk("resume_bor", 32'(bor), 32'd0);

    // Divisor 0: borrow on every tick.
    wr = 1'b1; ld = 1'b1; d = 8'd0; step();
    chk("d0_ld_bor", 32'(bor), 32'd0);
    wr = 1'b0; ld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("d0_cnt", 32'(cnt), 32'd0);
      chk("d0_bor", 32'(bor), 32'd1);
    end

    // Mid-count divisor change takes effect only at the next underflow.
    wr = 1'b1; ld = 1'b1; d = 8'd5; step();
    chk("d5_cnt", 32'(cnt), 32'd5);
    wr = 1'b0; ld = 1'b0; step(); step();
    chk("d5_cnt3", 32'(cnt), 32'd3);
    wr = 1'b1; d = 8'd1;
    for (int i = 0; i < 6; i++) begin
      step();
      wr = 1'b0;
      chk($sformatf("wr_mid_cnt%0d", i), 32'(cnt), 32'(exp4_c[i]));
      chk($sformatf("wr_mid_bor%0d", i), 32'(bor), 32'(exp4_b[i]));
    end
    wr = 1'b1; ld = 1'b1; d = 8'd9; step();
    chk("wrld_cnt", 32'(cnt), 32'd9);
    wr = 1'b0; ld = 1'b0;

    // Square wave with divisor 2.
    wr = 1'b1; ld = 1'b1; d = 8'd2; step();
    wr = 1'b0; ld = 1'b0;
    prev_tgl = tgl; flips = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (tgl !== prev_tgl) flips++;
      prev_tgl = tgl;
    end
`ifdef POKEY_DIV_TOGGLE_EN
    chk("tgl_flips", 32'(flips), 32'd4);
`else
    chk("tgl_flips", 32'(flips), 32'd0);
`endif

    // Async reset between edges.
    nrst = 1'b0; #1;
    chk("midrst_cnt", 32'(cnt), 32'd0);
    chk("midrst_tgl", 32'(tgl), 32'd0);
    chk("midrst_bor", 32'(bor), 32'd0);
    nrst = 1'b1;

    // Cascade: lo N=1, hi N=2 -> hi borrow every 6 base ticks.
    c_wr = 1'b1; c_ld = 1'b1; lo_d = 8'd1; hi_d = 8'd2; step();
    c_wr = 1'b0; c_ld = 1'b0; lo_tick = 1'b1;
    np = 0; cyc = 0;
    while (np < 4 && cyc < 200) begin
      step(); cyc++;
      if (hi_bor === 1'b1) begin pulses[np] = cyc; np++; end
    end
    chk("casc_pulses", 32'(np), 32'd4);
    for (int i = 1; i < np; i++) chk($sformatf("casc_gap%0d", i), 32'(pulses[i] - pulses[i-1]), 32'd6);
    chk("casc_nbor", {30'd0, lo_nbor, hi_nbor}, {30'd0, ~lo_bor, ~hi_bor});
    lo_hold = 1'b1; step(); step();
    frozen_lo = int'(lo_cnt); frozen_hi = int'(hi_cnt);
    for (int i = 0; i < 5; i++) step();
    chk("casc_hold_lo", 32'(lo_cnt), 32'(frozen_lo));
    chk("casc_hold_hi", 32'(hi_cnt), 32'(frozen_hi));
    chk("casc_hold_bor", {30'd0, lo_bor, hi_bor}, 32'd0);
`ifndef POKEY_DIV_TOGGLE_EN
    chk("casc_tgl", {30'd0, lo_tgl, hi_tgl}, 32'd0);
`endif
    lo_hold = 1'b0; lo_tick = 1'b0;

    // Randomized traffic checked against the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      enn  = ($urandom_range(0, 9) != 0);
      tick = ($urandom_range(0, 9) < 7);
      hold = ($urandom_range(0, 9) < 1);
      wr   = ($urandom_range(0, 9) < 1);
      ld   = ($urandom_range(0, 19) < 1);
      d    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
      if ($urandom_range(0, 199) == 0) begin
        nrst = 1'b0; #1 nrst = 1'b1;
      end
      step();
    end

    idle();
    step();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
